// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: redirect, imem request/response and decode handshake bundle
interface if_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, imem request issue, in-order prefetch FIFO and redirect flush
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    if_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
    logic [XLEN-1:0] q_pc [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count, outstanding, drop;
    logic [CW:0]     used;
    logic            accept, push, pop;
    assign used      = {1'b0, count} + {1'b0, outstanding};
    assign target_pc = bus.redirect_pc & ~XLEN'(3);
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (used < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = count != '0;
    assign bus.inst_pc        = q_pc[head];
    assign bus.inst_data      = q_data[head];
    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign push   = bus.imem_rsp_valid && drop == '0 && !bus.redirect_valid;
    assign pop    = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    // Requests after a redirect are sequential, so the next kept response's PC is a running counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(bus.imem_rsp_valid);
            // outstanding already covers responses still pending a drop, so every in-flight one becomes stale
            drop        <= outstanding - CW'(bus.imem_rsp_valid);
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && drop != '0)
                drop <= drop - 1'b1;
            if (push) begin
                q_pc[tail]   <= rsp_pc;
                q_data[tail] <= bus.imem_rsp_data;
                tail         <= tail + 1'b1;
                rsp_pc       <= rsp_pc + XLEN'(4);
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized traffic against an epoch-tagged queue model of fetch and decode
module tb_if_fetch_unit;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFFC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    if_fetch_unit_if #(.XLEN(XLEN)) bus();
    if_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int vectors = 0, errors = 0;
    int cyc = 0, epoch = 0, last_due = 0, accepts = 0, pops = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_q [$];
    logic [31:0] pend_pc [$];
    int          pend_due [$];
    int          pend_ep [$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask
    function automatic logic [31:0] word(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h5A3C_96E1;
    endfunction
    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, RPC);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        exp_q.delete();
        pend_pc.delete();
        pend_due.delete();
        pend_ep.delete();
        exp_pc   = RPC;
        last_due = cyc;
        rst      = 1'b0;
    endtask
    task automatic cycle(input int p_redir, input int p_rdy, input int p_irdy,
                         input int lat_lo, input int lat_hi, input logic [31:0] rpc);
        logic redir, rsp, acc, pop, exp_v;
        int   due;
        redir = $urandom_range(99) < p_redir;
        rsp   = pend_pc.size() != 0 && pend_due[0] <= cyc;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = $urandom_range(99) < p_rdy;
        bus.inst_ready     = $urandom_range(99) < p_irdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? word(pend_pc[0]) : $urandom;
        @(negedge clk);
        exp_v = !redir && (exp_q.size() + pend_pc.size() < DEPTH);
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_v));
        if (exp_v)
            check("req_addr", bus.imem_req_addr, exp_pc);
        check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
        pop = exp_q.size() != 0 && bus.inst_ready && !redir;
        if (pop) begin
            check("inst_pc", bus.inst_pc, exp_q[0]);
            check("inst_data", bus.inst_data, word(exp_q[0]));
            void'(exp_q.pop_front());
            pops++;
        end
        acc = exp_v && bus.imem_req_ready;
        if (rsp) begin
            if (!redir && pend_ep[0] == epoch)
                exp_q.push_back(pend_pc[0]);
            void'(pend_pc.pop_front());
            void'(pend_due.pop_front());
            void'(pend_ep.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_pc = {rpc[31:2], 2'b00};
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due)
                due = last_due + 1;
            pend_pc.push_back(exp_pc);
            pend_due.push_back(due);
            pend_ep.push_back(epoch);
            last_due = due;
            exp_pc  += 32'd4;
            accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask
    initial begin
        int rdy_pat [4] = '{100, 0, 0, 100};
        do_reset();
        do_reset();
        // wrap from RESET_PC, then full-rate streaming with 1-cycle memory
        for (int i = 0; i < 20; i++) begin
            if (i == 10)
                pops = 0;
            cycle(0, 100, 100, 1, 1, 32'h0);
        end
        check("throughput_pops", 32'(pops), 32'd10);
        // backpressure: redirect to 0, decode stalled
        cycle(100, 100, 0, 1, 1, 32'h0);
        accepts = 0;
        for (int i = 0; i < 12; i++)
            cycle(0, 100, 0, 1, 1, 32'h0);
        check("stall_accepts", 32'(accepts), 32'(DEPTH));
        for (int i = 0; i < 12; i++)
            cycle(0, 100, 100, 1, 1, 32'h0);
        // request ready toggling 1,0,0,1
        for (int i = 0; i < 16; i++)
            cycle(0, rdy_pat[i % 4], 100, 1, 2, 32'h0);
        // three outstanding with 3-cycle latency, redirect to 0x103 as the first response lands
        cycle(100, 100, 100, 3, 3, 32'h200);
        for (int i = 0; i < 3; i++)
            cycle(0, 100, 100, 3, 3, 32'h0);
        check("outstanding_before_redirect", 32'(pend_pc.size()), 32'd3);
        cycle(100, 100, 100, 3, 3, 32'h103);
        check("redirect_addr", exp_pc, 32'h100);
        for (int i = 0; i < 12; i++)
            cycle(0, 100, 100, 1, 1, 32'h0);
        // redirect while a response arrives and decode pops
        for (int i = 0; i < 8; i++)
            cycle(0, 100, 100, 2, 2, 32'h0);
        cycle(100, 100, 100, 2, 2, 32'h400);
        for (int i = 0; i < 10; i++)
            cycle(0, 100, 100, 2, 2, 32'h0);
        // randomized traffic with a mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500)
                do_reset();
            cycle(4, 70, 70, 1, 4, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
